// File: rtl/pipe_stage_elastic_pkg.sv
// Shared pipeline-stage types: stage occupancy states and the EX/MEM control layout
// with its no-op (bubble) encoding.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } ps_state_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] load_type;
    logic [1:0] store_type;
    logic       wb_en;
    logic       mem_to_reg;
  } ex_mem_ctrl_t;

  localparam int unsigned EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);

  // Load/store types decode to "none"; every enable is off.
  localparam ex_mem_ctrl_t EX_MEM_CTRL_NOP = '{
    mem_read:   1'b0,
    mem_write:  1'b0,
    load_type:  3'b111,
    store_type: 2'b11,
    wb_en:      1'b0,
    mem_to_reg: 1'b0
  };

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready stream carrying a data payload and a control field.
// master drives valid/data/ctrl, slave drives ready.
interface pipe_stage_elastic_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 16
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );

endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register (payload + control) with flush-to-bubble.
// Define PIPE_STAGE_SKID_EN for the two-entry skid version with a registered in_ready.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_elastic_if.slave  in_bus,
  pipe_stage_elastic_if.master out_bus,
  output logic [1:0]           occupancy
);

  ps_state_e         state;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CTRL_W-1:0] out_ctrl_q;
  logic [1:0]        occ_q;
  logic              in_ready;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_bus.valid & in_ready;
  assign out_fire = out_valid_q & out_bus.ready;

  assign in_bus.ready  = in_ready;
  assign out_bus.valid = out_valid_q;
  assign out_bus.data  = out_data_q;
  assign out_bus.ctrl  = out_ctrl_q;
  assign occupancy     = occ_q;

`ifdef PIPE_STAGE_SKID_EN

  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic              in_ready_q;

  assign in_ready = in_ready_q;

  // in_ready is updated only from the next state, so it never depends on out_ready
  // within a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PS_EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctrl_q  <= CTRL_RST;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else if (flush) begin
      state       <= PS_EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctrl_q  <= CTRL_RST;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (in_fire) begin
            state       <= PS_ONE;
            out_valid_q <= 1'b1;
            out_data_q  <= in_bus.data;
            out_ctrl_q  <= in_bus.ctrl;
            occ_q       <= 2'd1;
          end
        end
        PS_ONE: begin
          if (in_fire && out_fire) begin
            out_data_q <= in_bus.data;
            out_ctrl_q <= in_bus.ctrl;
          end else if (in_fire) begin
            // Downstream stalled: park the new entry behind the presented one.
            state       <= PS_TWO;
            skid_data_q <= in_bus.data;
            skid_ctrl_q <= in_bus.ctrl;
            in_ready_q  <= 1'b0;
            occ_q       <= 2'd2;
          end else if (out_fire) begin
            state       <= PS_EMPTY;
            out_valid_q <= 1'b0;
            out_ctrl_q  <= CTRL_RST;
            occ_q       <= 2'd0;
          end
        end
        PS_TWO: begin
          if (out_fire) begin
            state      <= PS_ONE;
            out_data_q <= skid_data_q;
            out_ctrl_q <= skid_ctrl_q;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd1;
          end
        end
        default: begin
          state       <= PS_EMPTY;
          out_valid_q <= 1'b0;
          out_ctrl_q  <= CTRL_RST;
          in_ready_q  <= 1'b1;
          occ_q       <= 2'd0;
        end
      endcase
    end
  end

`else

  // Without a skid slot the stage can only accept when its single entry leaves.
  assign in_ready = out_bus.ready | ~out_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PS_EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctrl_q  <= CTRL_RST;
      occ_q       <= 2'd0;
    end else if (flush) begin
      state       <= PS_EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctrl_q  <= CTRL_RST;
      occ_q       <= 2'd0;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (in_fire) begin
            state       <= PS_ONE;
            out_valid_q <= 1'b1;
            out_data_q  <= in_bus.data;
            out_ctrl_q  <= in_bus.ctrl;
            occ_q       <= 2'd1;
          end
        end
        PS_ONE: begin
          // in_fire here implies out_fire, so the entry is simply replaced.
          if (in_fire) begin
            out_data_q <= in_bus.data;
            out_ctrl_q <= in_bus.ctrl;
          end else if (out_fire) begin
            state       <= PS_EMPTY;
            out_valid_q <= 1'b0;
            out_ctrl_q  <= CTRL_RST;
            occ_q       <= 2'd0;
          end
        end
        default: begin
          state       <= PS_EMPTY;
          out_valid_q <= 1'b0;
          out_ctrl_q  <= CTRL_RST;
          occ_q       <= 2'd0;
        end
      endcase
    end
  end

`endif

endmodule
